lsu_rmw: RTL and testbench

- Load/store unit between the RISC-V datapath (ALU address, rs2 data, funct3) and a word-only data memory.
- Handles sub-word stores (sb/sh) as read-modify-write sequences: word read, lane merge, word write.
- Handles all loads (lb/lh/lw/lbu/lhu) with lane extraction and sign/zero extension.
- Stalls the core through a ready/done handshake and flags misaligned accesses.

---
 rtl/lsu_rmw_pkg.sv | 39 +++
 rtl/lsu_rmw_if.sv | 25 ++
 rtl/lsu_lane.sv | 56 +++++
 rtl/lsu_rmw.sv | 123 ++++++++++++
 tb/tb_lsu_rmw.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_rmw_pkg.sv
// lsu_rmw_pkg: shared types for the load/store unit.
// Holds the RISC-V funct3 width codes, the LSU state encoding and the
// decode helper that rejects misaligned or illegal accesses.
package lsu_rmw_pkg;

    typedef enum logic [2:0] {
        MW_B  = 3'b000,
        MW_H  = 3'b001,
        MW_W  = 3'b010,
        MW_BU = 3'b100,
        MW_HU = 3'b101
    } mem_width_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        ERR
    } lsu_state_e;

    // Unsigned codes exist only for loads; halves need addr[0]=0, words addr[1:0]=0.
    function automatic logic op_is_bad(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] byte_off);
        logic bad;
        bad = 1'b0;
        case (funct3)
            MW_B:    bad = 1'b0;
            MW_BU:   bad = is_store;
            MW_H:    bad = byte_off[0];
            MW_HU:   bad = is_store | byte_off[0];
            MW_W:    bad = (byte_off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// lsu_rmw_if: core-side request/response bus of the load/store unit.
// The core is the master; the LSU is the slave.
interface lsu_rmw_if;

    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req, we, funct3, addr, wdata,
        input  ready, done, err, rdata
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output ready, done, err, rdata
    );

endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: byte-lane datapath of the LSU.
// Merges store data into an old memory word and extracts/extends load
// data from a memory word, both selected by funct3 and the byte offset.
module lsu_lane
    import lsu_rmw_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] merged,
    output logic [31:0] loaded
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Replace only the addressed byte or half of the old word with store data.
    always_comb begin
        merged = new_data;
        case (funct3)
            MW_B: begin
                merged = old_word;
                case (byte_off)
                    2'd0:    merged[7:0]   = new_data[7:0];
                    2'd1:    merged[15:8]  = new_data[7:0];
                    2'd2:    merged[23:16] = new_data[7:0];
                    default: merged[31:24] = new_data[7:0];
                endcase
            end
            MW_H: begin
                merged = old_word;
                if (byte_off[1]) merged[31:16] = new_data[15:0];
                else             merged[15:0]  = new_data[15:0];
            end
            default: merged = new_data;
        endcase
    end

    // Pick the addressed lane of the word and sign- or zero-extend it.
    always_comb begin
        shifted = old_word >> {byte_off, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = byte_off[1] ? old_word[31:16] : old_word[15:0];
        loaded  = old_word;
        case (funct3)
            MW_B:    loaded = {{24{byte_v[7]}}, byte_v};
            MW_BU:   loaded = {24'h000000, byte_v};
            MW_H:    loaded = {{16{half_v[15]}}, half_v};
            MW_HU:   loaded = {16'h0000, half_v};
            default: loaded = old_word;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit between the core and a word-only data memory.
// Sub-word stores become read-merge-write sequences, loads are lane
// extracted and extended, and bad accesses raise err without touching memory.
module lsu_rmw
    import lsu_rmw_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_rmw_if.slave      core,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [31:0]   mem_rdata,
    output logic          mem_we,
    output logic [31:0]   mem_wdata
);

    lsu_state_e    state;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [1:0]    off_q;
    logic [AW-1:0] waddr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          ready_q;
    logic          done_q;
    logic          err_q;
    logic          re_q;
    logic          mem_we_q;

    logic [31:0]   merged;
    logic [31:0]   loaded;
    logic          unused_addr_hi;

    // Upper address bits wrap within memory and are deliberately dropped.
    assign unused_addr_hi = ^core.addr[31:AW+2];

    lsu_lane u_lane (
        .funct3   (funct3_q),
        .byte_off (off_q),
        .old_word (mem_rdata),
        .new_data (wdata_q),
        .merged   (merged),
        .loaded   (loaded)
    );

    // Operation sequencer: latches the op on accept and drives registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            waddr_q  <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            re_q     <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            re_q     <= 1'b0;
            mem_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (core.req) begin
                        we_q     <= core.we;
                        funct3_q <= core.funct3;
                        off_q    <= core.addr[1:0];
                        waddr_q  <= core.addr[AW+1:2];
                        wdata_q  <= core.wdata;
                        ready_q  <= 1'b0;
                        if (op_is_bad(core.we, core.funct3, core.addr[1:0])) begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end else if (core.we && (core.funct3 == MW_W)) begin
                            state    <= WR;
                            mem_we_q <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            state <= RD;
                            re_q  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state    <= MRG;
                    mem_we_q <= we_q;
                    done_q   <= 1'b1;
                end
                MRG: begin
                    if (!we_q) rdata_q <= loaded;
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                WR, ERR: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign core.ready = ready_q;
    assign core.done  = done_q;
    assign core.err   = err_q;
    assign core.rdata = (state == MRG && !we_q) ? loaded : rdata_q;

    assign mem_addr  = waddr_q;
    assign mem_re    = re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = !mem_we_q      ? 32'h0  :
                       (state == MRG) ? merged : wdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: directed self-checking bench for lsu_rmw with a behavioural
// synchronous-read word memory and hand-computed expected values.
module tb_lsu_rmw;
    import lsu_rmw_pkg::*;

    localparam int AW = 6;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [31:0]   mem_rdata = 32'h0;
    logic [31:0]   mem_wdata;

    logic [31:0]   mem [64] = '{default: 32'h0};
    logic          pl_en   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = 32'h0;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            lat;
    int            n_re;
    int            n_we;
    logic [31:0]   we_data;
    logic [31:0]   done_rdata;
    logic          got_done;
    logic          got_err;
    logic          ready_busy;

    lsu_rmw_if bus ();

    lsu_rmw #(.AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .core      (bus),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    // Word memory: one-cycle synchronous read, bench preload takes priority over writes.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = AW'(idx);
        pl_data = val;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Drives one op, holds req until done/err, records what happened cycle by cycle.
    task automatic apply_stimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] d, input logic alter);
        logic fin;
        @(negedge clk);
        bus.req    = 1'b1;
        bus.we     = w;
        bus.funct3 = f3;
        bus.addr   = a;
        bus.wdata  = d;
        @(posedge clk);
        lat = 0; n_re = 0; n_we = 0; fin = 1'b0;
        we_data = 32'h0; done_rdata = 32'h0;
        got_done = 1'b0; got_err = 1'b0; ready_busy = 1'b0;
        while (!fin && lat < 8) begin
            @(negedge clk);
            lat++;
            if (alter) begin
                bus.addr  = a ^ 32'h0000_0004;
                bus.wdata = ~d;
            end
            if (mem_re) n_re++;
            if (mem_we) begin
                n_we++;
                we_data = mem_wdata;
            end
            if (bus.done || bus.err) begin
                fin        = 1'b1;
                got_done   = bus.done;
                got_err    = bus.err;
                done_rdata = bus.rdata;
            end else if (bus.ready) begin
                ready_busy = 1'b1;
            end
        end
        bus.req = 1'b0;
    endtask

    initial begin
        logic [2:0]  ld_f3  [5];
        logic [31:0] ld_adr [5];
        logic [31:0] ld_exp [5];
        logic        er_we  [4];
        logic [2:0]  er_f3  [4];
        logic [31:0] er_adr [4];

        ld_f3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        ld_adr = '{32'd40, 32'd40, 32'd42, 32'd42, 32'd40};
        ld_exp = '{32'hffffff80, 32'h00000080, 32'hffff8001, 32'h00008001, 32'h8001ff80};
        er_we  = '{1'b1, 1'b0, 1'b0, 1'b1};
        er_f3  = '{3'b001, 3'b010, 3'b011, 3'b100};
        er_adr = '{32'd21, 32'd42, 32'd40, 32'd40};

        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000;
        bus.addr = 32'h0; bus.wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst ready", {31'b0, bus.ready}, 32'd1);
        check_output("rst done", {31'b0, bus.done}, 32'd0);
        check_output("rst err", {31'b0, bus.err}, 32'd0);
        check_output("rst mem_re", {31'b0, mem_re}, 32'd0);
        check_output("rst mem_we", {31'b0, mem_we}, 32'd0);
        check_output("rst rdata", bus.rdata, 32'h0);
        check_output("rst mem_addr", {26'b0, mem_addr}, 32'h0);
        check_output("rst mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;

        // sh at addr 20 over 0x12345678
        preload(5, 32'h12345678);
        apply_stimulus(1'b1, 3'b001, 32'd20, 32'hdeadc0de, 1'b0);
        check_output("sh20 latency", 32'(lat), 32'd2);
        check_output("sh20 re count", 32'(n_re), 32'd1);
        check_output("sh20 we count", 32'(n_we), 32'd1);
        check_output("sh20 wdata", we_data, 32'h1234c0de);
        check_output("sh20 done", {31'b0, got_done}, 32'd1);
        @(negedge clk);
        check_output("sh20 mem5", mem[5], 32'h1234c0de);
        check_output("sh20 ready after", {31'b0, bus.ready}, 32'd1);

        // Back-to-back sh@22 then sb@21
        preload(5, 32'h12345678);
        apply_stimulus(1'b1, 3'b001, 32'd22, 32'h0000beef, 1'b0);
        check_output("sh22 wdata", we_data, 32'hbeef5678);
        check_output("sh22 ready busy", {31'b0, ready_busy}, 32'd0);
        apply_stimulus(1'b1, 3'b000, 32'd21, 32'h000000aa, 1'b0);
        check_output("sb21 wdata", we_data, 32'hbeefaa78);
        check_output("sb21 latency", 32'(lat), 32'd2);
        check_output("sb21 ready busy", {31'b0, ready_busy}, 32'd0);
        @(negedge clk);
        check_output("sb21 mem5", mem[5], 32'hbeefaa78);

        // Loads from 0x8001ff80
        preload(10, 32'h8001ff80);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, ld_f3[i], ld_adr[i], 32'h0, 1'b0);
            check_output($sformatf("load%0d rdata", i), done_rdata, ld_exp[i]);
            check_output($sformatf("load%0d latency", i), 32'(lat), 32'd2);
            check_output($sformatf("load%0d re count", i), 32'(n_re), 32'd1);
            check_output($sformatf("load%0d we count", i), 32'(n_we), 32'd0);
        end
        @(negedge clk);
        check_output("lw rdata held", bus.rdata, 32'h8001ff80);

        // sw at addr 44
        apply_stimulus(1'b1, 3'b010, 32'd44, 32'hc001c0de, 1'b0);
        check_output("sw44 latency", 32'(lat), 32'd1);
        check_output("sw44 re count", 32'(n_re), 32'd0);
        check_output("sw44 we count", 32'(n_we), 32'd1);
        check_output("sw44 wdata", we_data, 32'hc001c0de);
        @(negedge clk);
        check_output("sw44 mem11", mem[11], 32'hc001c0de);

        // Misaligned / illegal ops
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(er_we[i], er_f3[i], er_adr[i], 32'h55555555, 1'b0);
            check_output($sformatf("err%0d err", i), {31'b0, got_err}, 32'd1);
            check_output($sformatf("err%0d done", i), {31'b0, got_done}, 32'd0);
            check_output($sformatf("err%0d latency", i), 32'(lat), 32'd1);
            check_output($sformatf("err%0d mem access", i), 32'(n_re + n_we), 32'd0);
        end
        @(negedge clk);
        check_output("err mem5 kept", mem[5], 32'hbeefaa78);
        check_output("err mem10 kept", mem[10], 32'h8001ff80);
        check_output("err rdata kept", bus.rdata, 32'h8001ff80);

        // Operands altered while busy are ignored after accept
        apply_stimulus(1'b1, 3'b000, 32'd44, 32'h00000055, 1'b1);
        check_output("held sb wdata", we_data, 32'hc001c055);
        @(negedge clk);
        check_output("held mem11", mem[11], 32'hc001c055);
        check_output("held mem12", mem[12], 32'h0);

        // High address bits wrap
        apply_stimulus(1'b1, 3'b010, 32'hffffff08, 32'ha5a5a5a5, 1'b0);
        check_output("wrap mem_addr", {26'b0, mem_addr}, 32'd2);
        @(negedge clk);
        check_output("wrap mem2", mem[2], 32'ha5a5a5a5);

        // Reset during MRG of sh at addr 20
        preload(5, 32'h12345678);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b001;
        bus.addr = 32'd20; bus.wdata = 32'hdeadc0de;
        @(posedge clk);
        @(negedge clk);
        check_output("rstmrg RD re", {31'b0, mem_re}, 32'd1);
        @(negedge clk);
        check_output("rstmrg MRG we", {31'b0, mem_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        bus.req = 1'b0;
        check_output("rstmrg we drop", {31'b0, mem_we}, 32'd0);
        check_output("rstmrg wdata", mem_wdata, 32'h0);
        check_output("rstmrg ready", {31'b0, bus.ready}, 32'd1);
        check_output("rstmrg rdata", bus.rdata, 32'h0);
        check_output("rstmrg done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rstmrg mem5", mem[5], 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
